// File: rtl/peripheral_dbg_pu_or1k_jsp_pkg.sv
// Shared definitions for the JTAG serial port TX serializer and RX deserializer.
package peripheral_dbg_pu_or1k_jsp_pkg;

    localparam int JSP_HDR_BITS   = 4;
    localparam int JSP_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        JSP_IDLE = 2'd0,
        JSP_HDR  = 2'd1,
        JSP_DATA = 2'd2,
        JSP_FIN  = 2'd3
    } jsp_state_e;

    // Byte count of a transfer: what the fifo holds, clipped to the per-transfer limit.
    function automatic logic [JSP_HDR_BITS-1:0] jsp_clip_count(
        input logic [JSP_HDR_BITS-1:0] avail,
        input logic [JSP_HDR_BITS-1:0] max_bytes
    );
        return (avail < max_bytes) ? avail : max_bytes;
    endfunction

endpackage

// File: rtl/peripheral_dbg_pu_or1k_jsp_tx_serializer.sv
// Pop side of the JTAG serial port TX path. Each transfer shifts out a
// byte-count header LSB-first followed by that many bytes popped from the
// bytefifo, also LSB-first. The next field is loaded on the SHIFT_EN that
// consumes the last bit of the current one, so fields are back to back.
module peripheral_dbg_pu_or1k_jsp_tx_serializer
    import peripheral_dbg_pu_or1k_jsp_pkg::*;
#(
    parameter int MAX_BYTES = 8,
    parameter int HDR_BITS  = JSP_HDR_BITS
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                START,
    input  logic                SHIFT_EN,
    input  logic                ABORT,
    input  logic [7:0]          FIFO_DATA,
    input  logic [HDR_BITS-1:0] FIFO_BYTES_AVAIL,
    output logic                FIFO_EN,
    output logic                FIFO_PUSH_POPn,
    output logic                TDO,
    output logic                BUSY,
    output logic                DONE,
    output logic [HDR_BITS-1:0] XFER_COUNT
);

    localparam logic [HDR_BITS-1:0] MAX_CNT  = HDR_BITS'(MAX_BYTES);
    localparam logic [2:0]          HDR_LAST = 3'(HDR_BITS - 1);
    localparam logic [2:0]          DAT_LAST = 3'd7;

    jsp_state_e          state_q, state_d;
    logic [7:0]          sreg_q, sreg_d;
    logic [2:0]          bitcnt_q, bitcnt_d;
    logic [HDR_BITS-1:0] rem_q, rem_d;
    logic [HDR_BITS-1:0] xfer_q, xfer_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pop_c;
    logic                last_bit_c;
    logic [HDR_BITS-1:0] cnt_c;

    // Next-state logic: header/data sequencing, field loads and pop strobe.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bitcnt_d   = bitcnt_q;
        rem_d      = rem_q;
        xfer_d     = xfer_q;
        pop_c      = 1'b0;
        cnt_c      = jsp_clip_count(FIFO_BYTES_AVAIL, MAX_CNT);
        last_bit_c = (state_q == JSP_HDR) ? (bitcnt_q == HDR_LAST) : (bitcnt_q == DAT_LAST);

        if (ABORT) begin
            // Leaving shift-DR drops the transfer; clearing sreg parks TDO low.
            state_d  = JSP_IDLE;
            sreg_d   = '0;
            bitcnt_d = '0;
            rem_d    = '0;
        end else begin
            case (state_q)
                JSP_IDLE: begin
                    if (START) begin
                        xfer_d   = cnt_c;
                        sreg_d   = 8'(cnt_c);
                        rem_d    = cnt_c;
                        bitcnt_d = '0;
                        state_d  = JSP_HDR;
                    end
                end
                JSP_HDR, JSP_DATA: begin
                    if (SHIFT_EN) begin
                        if (!last_bit_c) begin
                            sreg_d   = sreg_q >> 1;
                            bitcnt_d = bitcnt_q + 3'd1;
                        end else if (rem_q == '0) begin
                            sreg_d   = '0;
                            bitcnt_d = '0;
                            state_d  = JSP_FIN;
                        end else begin
                            sreg_d   = FIFO_DATA;
                            pop_c    = 1'b1;
                            rem_d    = rem_q - 1'b1;
                            bitcnt_d = '0;
                            state_d  = JSP_DATA;
                        end
                    end
                end
                JSP_FIN: begin
                    state_d = JSP_IDLE;
                end
                default: begin
                    state_d = JSP_IDLE;
                end
            endcase
        end

        busy_d = (state_d == JSP_HDR) || (state_d == JSP_DATA);
        done_d = (state_d == JSP_FIN);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q  <= JSP_IDLE;
            sreg_q   <= '0;
            bitcnt_q <= '0;
            rem_q    <= '0;
            xfer_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            bitcnt_q <= bitcnt_d;
            rem_q    <= rem_d;
            xfer_q   <= xfer_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // The pop must land in the same cycle as the load; reset suppresses it.
    assign FIFO_EN        = pop_c & RSTN;
    assign FIFO_PUSH_POPn = 1'b0;
    assign TDO            = sreg_q[0];
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign XFER_COUNT     = xfer_q;

endmodule

// File: tb/tb_peripheral_dbg_pu_or1k_jsp_tx_serializer.sv
// Bench for the JSP TX serializer: two instances (MAX_BYTES 8 and 4) share
// control inputs, each with its own bench-side bytefifo. A bit-stream model
// predicts TDO/BUSY/DONE/FIFO_EN/XFER_COUNT every cycle.
module tb_peripheral_dbg_pu_or1k_jsp_tx_serializer;

    localparam int NCH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, start, shift_en, abort;
    logic [7:0] fifo_data  [NCH];
    logic [3:0] fifo_avail [NCH];
    logic       fifo_en    [NCH];
    logic       push_popn  [NCH];
    logic       tdo        [NCH];
    logic       busy       [NCH];
    logic       done       [NCH];
    logic [3:0] xfer       [NCH];

    peripheral_dbg_pu_or1k_jsp_tx_serializer #(.MAX_BYTES(8)) u_dut8 (
        .CLK(clk), .RSTN(rstn), .START(start), .SHIFT_EN(shift_en), .ABORT(abort),
        .FIFO_DATA(fifo_data[0]), .FIFO_BYTES_AVAIL(fifo_avail[0]),
        .FIFO_EN(fifo_en[0]), .FIFO_PUSH_POPn(push_popn[0]), .TDO(tdo[0]),
        .BUSY(busy[0]), .DONE(done[0]), .XFER_COUNT(xfer[0])
    );

    peripheral_dbg_pu_or1k_jsp_tx_serializer #(.MAX_BYTES(4)) u_dut4 (
        .CLK(clk), .RSTN(rstn), .START(start), .SHIFT_EN(shift_en), .ABORT(abort),
        .FIFO_DATA(fifo_data[1]), .FIFO_BYTES_AVAIL(fifo_avail[1]),
        .FIFO_EN(fifo_en[1]), .FIFO_PUSH_POPn(push_popn[1]), .TDO(tdo[1]),
        .BUSY(busy[1]), .DONE(done[1]), .XFER_COUNT(xfer[1])
    );

    // Bench-side bytefifos
    logic [7:0] fifo_mem [NCH][256];
    int         rd [NCH];
    int         wr [NCH];
    int         pops [NCH];

    // Stream model: a transfer is just a list of bits and a read index
    bit         m_busy  [NCH];
    bit         m_fin   [NCH];
    int         m_idx   [NCH];
    int         m_nbits [NCH];
    bit         m_bits  [NCH][72];
    logic [3:0] m_xfer  [NCH];

    // Values seen in the most recent cycle, for the literal checks
    logic       cap_tdo  [NCH];
    logic       cap_en   [NCH];
    logic       cap_done [NCH];
    logic       cap_busy [NCH];
    logic [3:0] cap_xfer [NCH];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int fsize(input int ch);
        return wr[ch] - rd[ch];
    endfunction

    function automatic int max_of(input int ch);
        return (ch == 0) ? 8 : 4;
    endfunction

    task automatic check(input string name, input int ch, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s ch%0d @%0t: got %0h, want %0h", name, ch, $time, got, want);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        if (fsize(ch) < 8) begin
            fifo_mem[ch][wr[ch] % 256] = b;
            wr[ch]++;
        end
    endtask

    task automatic push_both(input logic [7:0] b);
        push(0, b);
        push(1, b);
    endtask

    task automatic flush();
        for (int ch = 0; ch < NCH; ch++) rd[ch] = wr[ch];
    endtask

    // One clock cycle: drive at negedge, compare, advance model, apply pops.
    task automatic cycle(input logic st, input logic sh, input logic ab, input logic rn);
        logic       exp_tdo, exp_en;
        logic [3:0] c4;
        logic [7:0] byt;
        int         cnt;
        @(negedge clk);
        start    = st;
        shift_en = sh;
        abort    = ab;
        rstn     = rn;
        for (int ch = 0; ch < NCH; ch++) begin
            fifo_data[ch]  = (fsize(ch) > 0) ? fifo_mem[ch][rd[ch] % 256] : 8'h00;
            fifo_avail[ch] = 4'(fsize(ch));
        end
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            exp_tdo = m_busy[ch] ? m_bits[ch][m_idx[ch]] : 1'b0;
            exp_en  = rn && !ab && sh && m_busy[ch] && (m_idx[ch] >= 3) &&
                      (((m_idx[ch] - 3) % 8) == 0) && (m_idx[ch] + 1 < m_nbits[ch]);
            check("tdo", ch, 32'(tdo[ch]), 32'(exp_tdo));
            check("busy", ch, 32'(busy[ch]), 32'(m_busy[ch]));
            check("done", ch, 32'(done[ch]), 32'(m_fin[ch]));
            check("fifo_en", ch, 32'(fifo_en[ch]), 32'(exp_en));
            check("push_popn", ch, 32'(push_popn[ch]), 32'd0);
            check("xfer_count", ch, 32'(xfer[ch]), 32'(m_xfer[ch]));
            cap_tdo[ch]  = tdo[ch];
            cap_en[ch]   = fifo_en[ch];
            cap_done[ch] = done[ch];
            cap_busy[ch] = busy[ch];
            cap_xfer[ch] = xfer[ch];

            if (!rn) begin
                m_busy[ch] = 1'b0;
                m_fin[ch]  = 1'b0;
                m_xfer[ch] = 4'd0;
            end else if (ab) begin
                m_busy[ch] = 1'b0;
                m_fin[ch]  = 1'b0;
            end else if (m_fin[ch]) begin
                m_fin[ch] = 1'b0;
            end else if (m_busy[ch]) begin
                if (sh) begin
                    if (m_idx[ch] + 1 == m_nbits[ch]) begin
                        m_busy[ch] = 1'b0;
                        m_fin[ch]  = 1'b1;
                    end else begin
                        m_idx[ch]++;
                    end
                end
            end else if (st) begin
                cnt         = (fsize(ch) < max_of(ch)) ? fsize(ch) : max_of(ch);
                c4          = 4'(cnt);
                m_xfer[ch]  = c4;
                m_nbits[ch] = 4 + 8 * cnt;
                for (int b = 0; b < 4; b++) m_bits[ch][b] = c4[b];
                for (int k = 0; k < cnt; k++) begin
                    byt = fifo_mem[ch][(rd[ch] + k) % 256];
                    for (int b = 0; b < 8; b++) m_bits[ch][4 + 8 * k + b] = byt[b];
                end
                m_idx[ch]  = 0;
                m_busy[ch] = 1'b1;
            end

            if (fifo_en[ch] === 1'b1 && fsize(ch) > 0) begin
                rd[ch]++;
                pops[ch]++;
            end
        end
    endtask

    task automatic run_until_idle(input string name, input int budget, input bit rnd);
        int n = 0;
        while ((m_busy[0] || m_fin[0] || m_busy[1] || m_fin[1]) && n < budget) begin
            cycle(1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b1);
            n++;
        end
        if (m_busy[0] || m_fin[0] || m_busy[1] || m_fin[1]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_%s: still busy after %0d cycles, want idle", name, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] pin_stream;
        logic [3:0]  hdr8, hdr4;
        int          p0, p1;

        rstn = 1'b0; start = 1'b0; shift_en = 1'b0; abort = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            rd[ch] = 0; wr[ch] = 0; pops[ch] = 0;
            m_busy[ch] = 1'b0; m_fin[ch] = 1'b0; m_idx[ch] = 0; m_nbits[ch] = 0;
            m_xfer[ch] = 4'd0;
            fifo_data[ch] = 8'h00; fifo_avail[ch] = 4'd0;
        end

        // Reset
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_busy", 0, 32'(cap_busy[0]), 32'd0);
        check("rst_tdo", 0, 32'(cap_tdo[0]), 32'd0);
        check("rst_xfer", 0, 32'(cap_xfer[0]), 32'd0);

        // Empty fifo: header 0000, DONE in cycle 5, no pops
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            check("empty_en", 0, 32'(cap_en[0]), 32'd0);
            check("empty_done", 0, 32'(cap_done[0]), (i == 5) ? 32'd1 : 32'd0);
            if (i == 1) check("empty_xfer", 0, 32'(cap_xfer[0]), 32'd0);
        end

        // A5,3C,01 with continuous shifting
        pin_stream = 28'b1100_10100101_00111100_10000000;
        push_both(8'hA5); push_both(8'h3C); push_both(8'h01);
        p0 = pops[0];
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            if (i <= 28) check("pin_tdo", 0, 32'(cap_tdo[0]), 32'(pin_stream[28 - i]));
            check("pin_pop", 0, 32'(cap_en[0]), (i == 4 || i == 12 || i == 20) ? 32'd1 : 32'd0);
            check("pin_done", 0, 32'(cap_done[0]), (i == 29) ? 32'd1 : 32'd0);
        end
        check("pin_pops", 0, 32'(pops[0] - p0), 32'd3);
        check("pin_xfer", 0, 32'(cap_xfer[0]), 32'd3);

        // Eight bytes queued: MAX 8 sends all, MAX 4 sends four
        flush();
        for (int k = 0; k < 8; k++) push_both(8'($urandom_range(0, 255)));
        hdr8 = 4'b1000;
        hdr4 = 4'b0100;
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            check("hdr8", 0, 32'(cap_tdo[0]), 32'(hdr8[i - 1]));
            check("hdr4", 1, 32'(cap_tdo[1]), 32'(hdr4[i - 1]));
        end
        run_until_idle("max", 200, 1'b0);
        check("max4_avail", 1, 32'(fsize(1)), 32'd4);
        check("max8_avail", 0, 32'(fsize(0)), 32'd0);
        check("max4_xfer", 1, 32'(cap_xfer[1]), 32'd4);
        check("max8_xfer", 0, 32'(cap_xfer[0]), 32'd8);

        // Random SHIFT_EN stalls on a 3-byte transfer
        flush();
        for (int k = 0; k < 3; k++) push_both(8'($urandom_range(0, 255)));
        p0 = pops[0]; p1 = pops[1];
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        run_until_idle("stall", 400, 1'b1);
        check("stall_pops", 0, 32'(pops[0] - p0), 32'd3);
        check("stall_pops", 1, 32'(pops[1] - p1), 32'd3);

        // ABORT during the third bit of byte 2 of 3
        flush();
        for (int k = 0; k < 3; k++) push_both(8'($urandom_range(0, 255)));
        p0 = pops[0];
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 14; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 16; i <= 19; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            check("abort_busy", 0, 32'(cap_busy[0]), 32'd0);
            check("abort_done", 0, 32'(cap_done[0]), 32'd0);
        end
        check("abort_pops", 0, 32'(pops[0] - p0), 32'd2);

        // Reset in the middle of the header, then a clean transfer
        flush();
        push_both(8'h5A); push_both(8'hC3);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("rstmid_busy", 0, 32'(cap_busy[0]), 32'd0);
        check("rstmid_tdo", 0, 32'(cap_tdo[0]), 32'd0);
        check("rstmid_xfer", 0, 32'(cap_xfer[0]), 32'd0);
        check("rstmid_done", 0, 32'(cap_done[0]), 32'd0);
        p0 = pops[0];
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        run_until_idle("rstmid", 100, 1'b0);
        check("rstmid_pops", 0, 32'(pops[0] - p0), 32'd2);
        check("rstmid_xfer2", 0, 32'(cap_xfer[0]), 32'd2);

        // START together with ABORT in IDLE is ignored
        push_both(8'h77);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("stab_busy", 0, 32'(cap_busy[0]), 32'd0);
        check("stab_xfer", 0, 32'(cap_xfer[0]), 32'd2);
        flush();

        // Randomized traffic: pushes, stalls, stray STARTs and rare ABORTs
        for (int t = 0; t < 40; t++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                int n = $urandom_range(0, 8 - fsize(ch));
                for (int k = 0; k < n; k++) push(ch, 8'($urandom_range(0, 255)));
            end
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            for (int c = 0; c < 300 && (m_busy[0] || m_fin[0] || m_busy[1] || m_fin[1]); c++) begin
                cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 59) == 0), 1'b1);
            end
            run_until_idle("rand", 300, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
